ahblite_apb_bridge: RTL

- AHB-Lite slave to APB bridge; connects to one slave-side output of the AHB-Lite interconnect (hsel/haddr/... from one interconnect slave port) and fans out to APB_SLV_NUM peripherals on a shared APB bus with per-slave PSEL. Converts each accepted AHB transfer into one APB SETUP+ACCESS sequence, inserting AHB wait states until PREADY.

---
 rtl/ahblite_apb_bridge_if.sv | 50 +++++
 rtl/ahblite_apb_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ahblite_apb_bridge_if.sv
// Signal bundle between an AHB-Lite interconnect slave port, the AHB-to-APB bridge and its APB peripherals.
// "slave" is the bridge's view; "master" is the surrounding system (AHB requester plus APB responders).
interface ahblite_apb_bridge_if #(
    parameter int AHB_AW      = 32,
    parameter int AHB_DW      = 32,
    parameter int APB_SLV_NUM = 8
);
    logic                          hsel_i;
    logic [AHB_AW-1:0]             haddr_i;
    logic                          hwrite_i;
    logic [1:0]                    htrans_i;
    logic [2:0]                    hsize_i;
    logic [AHB_DW-1:0]             hwdata_i;
    logic                          hready_i;
    logic [3:0]                    hprot_i;
    logic                          hreadyout_o;
    logic                          hresp_o;
    logic [AHB_DW-1:0]             hrdata_o;
    logic [APB_SLV_NUM-1:0]        psel_o;
    logic                          penable_o;
    logic [AHB_AW-1:0]             paddr_o;
    logic                          pwrite_o;
    logic [AHB_DW-1:0]             pwdata_o;
    logic [3:0]                    pstrb_o;
    logic [2:0]                    pprot_o;
    logic [APB_SLV_NUM*AHB_DW-1:0] prdata_i;
    logic [APB_SLV_NUM-1:0]        pready_i;
    logic [APB_SLV_NUM-1:0]        pslverr_i;
    // Bridge FSM state, exported for checkers: 0 IDLE, 1 SETUP, 2 ACCESS, 3 ERR1, 4 ERR2.
    logic [2:0]                    state_dbg;

    // AHB: a transfer is offered when hsel_i & hready_i & htrans_i[1]; it completes in the first
    // cycle with hreadyout_o=1. APB: psel_o alone is SETUP, psel_o & penable_o is ACCESS, and the
    // access ends on the cycle where the selected slave's pready_i is 1.
    modport slave (
        input  hsel_i, haddr_i, hwrite_i, htrans_i, hsize_i, hwdata_i, hready_i, hprot_i,
        input  prdata_i, pready_i, pslverr_i,
        output hreadyout_o, hresp_o, hrdata_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
        output state_dbg
    );

    modport master (
        output hsel_i, haddr_i, hwrite_i, htrans_i, hsize_i, hwdata_i, hready_i, hprot_i,
        output prdata_i, pready_i, pslverr_i,
        input  hreadyout_o, hresp_o, hrdata_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
        input  state_dbg
    );
endinterface

// File: rtl/ahblite_apb_bridge.sv
// AHB-Lite slave to multi-peripheral APB bridge: one SETUP+ACCESS per accepted AHB transfer.
// Define AHB2APB_APB4_EN to drive APB4 pstrb_o/pprot_o; otherwise both are tied to 0 (APB3).
module ahblite_apb_bridge #(
    parameter int AHB_AW      = 32,
    parameter int AHB_DW      = 32,
    parameter int APB_SLV_NUM = 8,
    parameter int APB_WIN     = 12
) (
    input logic                 clk,
    input logic                 rst_n,
    ahblite_apb_bridge_if.slave bus
);
    localparam int IDXW = (APB_SLV_NUM > 1) ? $clog2(APB_SLV_NUM) : 1;
    localparam int UW   = AHB_AW - APB_WIN;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [AHB_AW-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [AHB_DW-1:0] pwdata_q, pwdata_d;
    logic [AHB_DW-1:0] hrdata_q, hrdata_d;
`ifdef AHB2APB_APB4_EN
    logic [3:0]        pstrb_q, pstrb_d;
    logic [2:0]        pprot_q, pprot_d;
`endif

    logic              accept;
    logic              req_valid;
    logic [UW-1:0]     win_sel;
    logic              sel_pready;
    logic              sel_pslverr;
    logic [AHB_DW-1:0] sel_prdata;
    logic [APB_SLV_NUM-1:0] sel_onehot;

`ifdef AHB2APB_APB4_EN
    function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
        case (size[1:0])
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction
`endif

    // Everything above the slave index must be zero, so addresses past the last window error out.
    assign win_sel   = bus.haddr_i[AHB_AW-1:APB_WIN];
    assign req_valid = (win_sel < UW'(APB_SLV_NUM)) && (bus.hsize_i <= 3'd2);
    assign accept    = ((state_q == S_IDLE) || (state_q == S_ERR2)) &&
                       bus.hsel_i && bus.hready_i && bus.htrans_i[1];

    assign sel_pready  = bus.pready_i[idx_q];
    assign sel_pslverr = bus.pslverr_i[idx_q];
    assign sel_prdata  = bus.prdata_i[idx_q*AHB_DW +: AHB_DW];
    assign sel_onehot  = {{(APB_SLV_NUM-1){1'b0}}, 1'b1} << idx_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
`ifdef AHB2APB_APB4_EN
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
`endif
        // Address-phase capture; cannot fire while an APB access is in flight.
        if (accept) begin
            idx_d    = bus.haddr_i[APB_WIN +: IDXW];
            paddr_d  = {bus.haddr_i[AHB_AW-1:2], 2'b00};
            pwrite_d = bus.hwrite_i;
`ifdef AHB2APB_APB4_EN
            pstrb_d  = bus.hwrite_i ? strb_of(bus.hsize_i, bus.haddr_i[1:0]) : 4'h0;
            pprot_d  = {~bus.hprot_i[0], 1'b0, bus.hprot_i[1]};
`endif
        end

        case (state_q)
            S_IDLE, S_ERR2: begin
                if (accept) state_d = req_valid ? S_SETUP : S_ERR1;
                else        state_d = S_IDLE;
            end
            S_SETUP: begin
                // The cycle after accept is the AHB data phase, so hwdata_i is valid now.
                pwdata_d = bus.hwdata_i;
                state_d  = S_ACCESS;
            end
            S_ACCESS: begin
                if (sel_pready) begin
                    if (sel_pslverr) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_IDLE;
                        if (!pwrite_q) hrdata_d = sel_prdata;
                    end
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
`ifdef AHB2APB_APB4_EN
            pstrb_q  <= 4'h0;
            pprot_q  <= 3'b000;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
`ifdef AHB2APB_APB4_EN
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
`endif
        end
    end

    // Handshake outputs decode straight from the state register, so async reset acts immediately.
    assign bus.psel_o      = ((state_q == S_SETUP) || (state_q == S_ACCESS)) ? sel_onehot : '0;
    assign bus.penable_o   = (state_q == S_ACCESS);
    assign bus.hreadyout_o = !((state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_ERR1));
    assign bus.hresp_o     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.hrdata_o    = hrdata_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.state_dbg   = state_q;
`ifdef AHB2APB_APB4_EN
    assign bus.pstrb_o     = pstrb_q;
    assign bus.pprot_o     = pprot_q;
`else
    assign bus.pstrb_o     = 4'h0;
    assign bus.pprot_o     = 3'b000;
`endif
endmodule
